// File: rtl/noc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_pkg : arbitration state encoding and flit field helpers           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // The tail flag always sits in the top bit of a flit.
    function automatic int TAIL_BIT(input int width);
        return width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flit_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flit_fifo2 : 2-entry valid/ready flit buffer, simultaneous push/pop  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module flit_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q,  count_d;
    logic         w_push;
    logic         w_pop;

    assign o_valid = (count_q != 2'd0);
    // A full buffer still accepts when the head leaves in the same cycle.
    assign o_ready = (count_q != 2'd2) || i_ready;
    assign o_data  = mem_q[rd_ptr_q];
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/merge11_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | merge11_arbiter : packet-locked 2:1 round-robin flit merger with      |
// |                   per-packet source token                             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module merge11_arbiter
    import noc_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] In0_data,
    input  logic         In0_valid,
    output logic         In0_ready,
    input  logic [W-1:0] In1_data,
    input  logic         In1_valid,
    output logic         In1_ready,
    output logic [W-1:0] Out_data,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic         S_data,
    output logic         S_valid,
    input  logic         S_ready
);

    localparam int c_TB = TAIL_BIT(W);

    arb_state_e   state_q, state_d;
    logic         rr_q, rr_d;
    logic         s_valid_q, s_valid_d;
    logic         s_data_q, s_data_d;

    logic         w_fifo_in_ready;
    logic         w_fifo_in_valid;
    logic [W-1:0] w_fifo_in_data;
    logic         w_rdy0;
    logic         w_rdy1;
    logic         w_sel;
    logic         w_grant_vld;
    logic         w_s_space;
    logic         w_sel_tail;

    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        s_valid_d       = s_valid_q;
        s_data_d        = s_data_q;
        w_rdy0          = 1'b0;
        w_rdy1          = 1'b0;
        w_sel           = 1'b0;
        w_grant_vld     = 1'b0;
        w_fifo_in_valid = 1'b0;
        w_s_space       = !s_valid_q || S_ready;

        if (s_valid_q && S_ready) begin
            s_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (In0_valid && In1_valid) begin
                    w_grant_vld = 1'b1;
                    w_sel       = rr_q;
                end else if (In0_valid) begin
                    w_grant_vld = 1'b1;
                    w_sel       = 1'b0;
                end else if (In1_valid) begin
                    w_grant_vld = 1'b1;
                    w_sel       = 1'b1;
                end
                // A head needs room for both its flit and its source token.
                if (w_grant_vld && w_s_space && w_fifo_in_ready) begin
                    w_fifo_in_valid = 1'b1;
                    s_valid_d       = 1'b1;
                    s_data_d        = w_sel;
                    w_rdy0          = !w_sel;
                    w_rdy1          = w_sel;
                    if (w_sel ? In1_data[c_TB] : In0_data[c_TB]) begin
                        rr_d = !w_sel;
                    end else begin
                        state_d = w_sel ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0: begin
                w_sel           = 1'b0;
                w_rdy0          = w_fifo_in_ready;
                w_fifo_in_valid = In0_valid && w_fifo_in_ready;
                if (w_fifo_in_valid && In0_data[c_TB]) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end
            end
            LOCK1: begin
                w_sel           = 1'b1;
                w_rdy1          = w_fifo_in_ready;
                w_fifo_in_valid = In1_valid && w_fifo_in_ready;
                if (w_fifo_in_valid && In1_data[c_TB]) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        w_fifo_in_data = w_sel ? In1_data : In0_data;
        w_sel_tail     = w_fifo_in_data[c_TB];
    end

    // Readies are gated so nothing is accepted while reset is held.
    assign In0_ready = w_rdy0 && !RESET;
    assign In1_ready = w_rdy1 && !RESET;
    assign S_valid   = s_valid_q;
    assign S_data    = s_data_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            s_valid_q <= 1'b0;
            s_data_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

    flit_fifo2 #(
        .W (W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_data  (w_fifo_in_data),
        .i_valid (w_fifo_in_valid && !RESET),
        .o_ready (w_fifo_in_ready),
        .o_data  (Out_data),
        .o_valid (Out_valid),
        .i_ready (Out_ready)
    );

    logic w_unused;
    assign w_unused = w_sel_tail;

endmodule
`default_nettype wire

// File: tb/tb_merge11_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_merge11_arbiter : directed stimulus with a queue-level model       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_merge11_arbiter;

    localparam int W = 9;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] In0_data, In1_data, Out_data;
    logic         In0_valid, In0_ready, In1_valid, In1_ready;
    logic         Out_valid, Out_ready, S_data, S_valid, S_ready;

    always #5 CLK = ~CLK;

    merge11_arbiter #(.W(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .In0_data  (In0_data),
        .In0_valid (In0_valid),
        .In0_ready (In0_ready),
        .In1_data  (In1_data),
        .In1_valid (In1_valid),
        .In1_ready (In1_ready),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .S_data    (S_data),
        .S_valid   (S_valid),
        .S_ready   (S_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // pending flits per requester; element 0 is currently presented
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    // model: contents of the Out buffer and of the S slot
    logic [W-1:0] exp_out[$];
    logic         exp_s[$];
    int           m_lock = -1;
    logic         m_rr   = 1'b0;
    // observation logs
    logic [W-1:0] got_out[$];
    int           got_out_cyc[$];
    logic         got_s[$];
    int           first_acc = -1;
    int           cyc = 0;
    bit           in1_rdy_seen = 0;

    // requester drivers
    initial begin
        logic a0, a1;
        forever begin
            @(negedge CLK);
            a0 = In0_valid && In0_ready && !RESET;
            a1 = In1_valid && In1_ready && !RESET;
            @(posedge CLK);
            #1;
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            In0_valid = (q0.size() > 0);
            In0_data  = (q0.size() > 0) ? q0[0] : '0;
            In1_valid = (q1.size() > 0);
            In1_data  = (q1.size() > 0) ? q1[0] : '0;
        end
    end

    function automatic void accept(logic src, logic [W-1:0] d);
        if (first_acc < 0) first_acc = cyc;
        exp_out.push_back(d);
        if (m_lock < 0) begin
            exp_s.push_back(src);
            if (d[W-1]) m_rr = !src;
            else        m_lock = int'(src);
        end else begin
            chk("lock_owner", {31'd0, src}, m_lock);
            if (d[W-1]) begin
                m_lock = -1;
                m_rr   = !src;
            end
        end
    endfunction

    // compare process
    initial begin
        logic er0, er1, space, sspace, f0, f1;
        int   g;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RESET) begin
                exp_out.delete(); exp_s.delete();
                got_out.delete(); got_out_cyc.delete(); got_s.delete();
                m_lock = -1; m_rr = 1'b0; first_acc = -1;
                chk("rst_out_valid", Out_valid, 0);
                chk("rst_s_valid",   S_valid,   0);
                chk("rst_in0_ready", In0_ready, 0);
                chk("rst_in1_ready", In1_ready, 0);
                chk("rst_out_data",  Out_data,  0);
            end else begin
                space  = (exp_out.size() < 2) || Out_ready;
                sspace = (exp_s.size() == 0) || S_ready;
                er0 = 1'b0; er1 = 1'b0;
                if (m_lock == 0) er0 = space;
                else if (m_lock == 1) er1 = space;
                else begin
                    g = -1;
                    if (In0_valid && In1_valid) g = int'(m_rr);
                    else if (In0_valid) g = 0;
                    else if (In1_valid) g = 1;
                    if (g == 0) er0 = space && sspace;
                    if (g == 1) er1 = space && sspace;
                end
                chk("in0_ready", In0_ready, er0);
                chk("in1_ready", In1_ready, er1);
                chk("out_valid", Out_valid, exp_out.size() > 0);
                if (Out_valid && exp_out.size() > 0) chk("out_data", Out_data, exp_out[0]);
                chk("s_valid", S_valid, exp_s.size() > 0);
                if (S_valid && exp_s.size() > 0) chk("s_data", S_data, exp_s[0]);
                if (In1_ready) in1_rdy_seen = 1;

                if (Out_valid && Out_ready) begin
                    got_out.push_back(Out_data);
                    got_out_cyc.push_back(cyc);
                    if (exp_out.size() > 0) void'(exp_out.pop_front());
                end
                if (S_valid && S_ready) begin
                    got_s.push_back(S_data);
                    if (exp_s.size() > 0) void'(exp_s.pop_front());
                end
                f0 = In0_valid && In0_ready;
                f1 = In1_valid && In1_ready;
                if (f0 && f1) chk("single_grant", 1, 0);
                else if (f0) accept(1'b0, In0_data);
                else if (f1) accept(1'b1, In1_data);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic drain(string name);
        int k = 0;
        while ((q0.size() + q1.size() + exp_out.size() + exp_s.size() > 0) && k < 200) begin
            step();
            k++;
        end
        chk({name, "_drained"}, k < 200, 1);
        step(2);
    endtask

    task automatic wait_q0(int n, string name);
        int k = 0;
        while (q0.size() != n && k < 100) begin
            step();
            k++;
        end
        chk({name, "_wait"}, q0.size(), n);
    endtask

    task automatic clear_logs();
        got_out.delete(); got_out_cyc.delete(); got_s.delete();
        first_acc = -1;
    endtask

    task automatic chk_out(string name, int n, int e0, int e1 = 0, int e2 = 0, int e3 = 0);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_len"}, got_out.size(), n);
        for (int i = 0; i < n; i++)
            chk({name, "_flit"}, (i < got_out.size()) ? 32'(got_out[i]) : 32'hFFFF, e[i]);
    endtask

    task automatic chk_s(string name, int n, int s0, int s1 = 0);
        int e[2];
        e = '{s0, s1};
        chk({name, "_len"}, got_s.size(), n);
        for (int i = 0; i < n; i++)
            chk({name, "_tok"}, (i < got_s.size()) ? 32'(got_s[i]) : 32'hFFFF, e[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        Out_ready = 1'b1; S_ready = 1'b1;
        In0_valid = 1'b0; In0_data = '0; In1_valid = 1'b0; In1_data = '0;

        // contention straight out of reset
        q0.push_back(9'h1AA);
        q1.push_back(9'h1BB);
        step(3);
        RESET = 1'b0;
        drain("t030");
        chk_out("t030_out", 2, 'h1AA, 'h1BB);
        chk_s("t030_s", 2, 0, 1);
        chk("t030_rr_end", dut.rr_q, 0);

        // single requester, 3-flit packet
        clear_logs();
        in1_rdy_seen = 0;
        q0.push_back(9'h001); q0.push_back(9'h002); q0.push_back(9'h103);
        drain("t029");
        chk_out("t029_out", 3, 'h001, 'h002, 'h103);
        chk_s("t029_s", 1, 0);
        chk("t029_latency", (got_out_cyc.size() > 0) ? got_out_cyc[0] - first_acc : -1, 1);
        chk("t029_consec", (got_out_cyc.size() > 2) ? got_out_cyc[2] - got_out_cyc[0] : -1, 2);
        chk("t029_in1_ready", in1_rdy_seen, 0);

        // packet lock holds off the other requester
        clear_logs();
        q1.push_back(9'h011);
        begin
            int k = 0;
            while (q1.size() != 0 && k < 100) begin step(); k++; end
            chk("t031_head_wait", q1.size(), 0);
        end
        q0.push_back(9'h1CC);
        step(3);
        chk("t031_in0_blocked", q0.size(), 1);
        chk("t031_out_so_far", got_out.size(), 1);
        q1.push_back(9'h112);
        drain("t031");
        chk_out("t031_out", 3, 'h011, 'h112, 'h1CC);
        chk_s("t031_s", 2, 1, 0);

        // output backpressure fills the buffer
        clear_logs();
        Out_ready = 1'b0;
        q0.push_back(9'h005); q0.push_back(9'h006); q0.push_back(9'h007); q0.push_back(9'h108);
        step(4);
        chk("t032_accepted", q0.size(), 2);
        chk("t032_in0_ready", In0_ready, 0);
        chk("t032_out_none", got_out.size(), 0);
        chk("t032_fifo_count", dut.u_fifo.count_q, 2);
        Out_ready = 1'b1;
        drain("t032");
        chk_out("t032_out", 4, 'h005, 'h006, 'h007, 'h108);
        chk_s("t032_s", 1, 0);

        // token backpressure stalls the next head
        clear_logs();
        S_ready = 1'b0;
        q0.push_back(9'h1A1); q0.push_back(9'h1A2);
        step(4);
        chk("t033_stalled", q0.size(), 1);
        chk("t033_s_valid", S_valid, 1);
        chk("t033_s_data", S_data, 0);
        chk("t033_out_so_far", got_out.size(), 1);
        S_ready = 1'b1;
        drain("t033");
        chk_out("t033_out", 2, 'h1A1, 'h1A2);
        chk_s("t033_s", 2, 0, 0);

        // reset in the middle of a packet
        clear_logs();
        q0.push_back(9'h021); q0.push_back(9'h022); q0.push_back(9'h023); q0.push_back(9'h124);
        wait_q0(2, "t034");
        RESET = 1'b1;
        #1;
        chk("t034_out_valid", Out_valid, 0);
        chk("t034_s_valid", S_valid, 0);
        chk("t034_in0_ready", In0_ready, 0);
        chk("t034_s_data", S_data, 0);
        @(negedge CLK);
        step();
        RESET = 1'b0;
        drain("t034");
        chk_out("t034_out", 2, 'h023, 'h124);
        chk_s("t034_s", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
